// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the MEM stage: load op encoding,
// MEM-stage FSM states and the EX/MEM and MEM/WB stage-register layouts.
package rv32i_types;

    // Load flavours, encoded as the funct3 field of the load instruction.
    typedef enum logic [2:0] {
        load_lb  = 3'b000,
        load_lh  = 3'b001,
        load_lw  = 3'b010,
        load_lbu = 3'b100,
        load_lhu = 3'b101
    } load_ops;

    typedef enum logic {
        mem_idle = 1'b0,
        mem_wait = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic       regf_we;
        logic [1:0] wb_sel;
    } control_wb_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [63:0] order;
        logic [31:0] inst;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [4:0]  rd_s;
        control_wb_t control_wb;
        logic [31:0] alu_out;
        logic        branch;
        logic [31:0] u_imm;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
        load_ops     load_op;
    } ex_mem_stage_reg_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [63:0] order;
        logic [31:0] inst;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [4:0]  rd_s;
        control_wb_t control_wb;
        logic [31:0] alu_out;
        logic        branch;
        logic [31:0] u_imm;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic [31:0] ld_data;
    } mem_wb_stage_reg_t;

    // Extend an 8-bit value to 32 bits, sign-extending when sgn is set.
    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    // Extend a 16-bit value to 32 bits, sign-extending when sgn is set.
    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to the load flavour.
module load_align
    import rv32i_types::*;
(
    input  load_ops     load_op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lane, then extend it for the requested load type.
    always_comb begin
        byte_s  = 8'h00;
        half_s  = 16'h0000;
        ld_data = 32'h0000_0000;
        case (off)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (load_op)
            load_lb:  ld_data = ext8(byte_s, 1'b1);
            load_lbu: ld_data = ext8(byte_s, 1'b0);
            load_lh:  ld_data = ext16(half_s, 1'b1);
            load_lhu: ld_data = ext16(half_s, 1'b0);
            load_lw:  ld_data = rdata;
            default:  ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RV32I pipeline. Issues one data-memory access per
// memory instruction, stalls the front of the pipeline until the response
// pulse, aligns load data and registers the MEM/WB stage register.
module mem_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  ex_mem_stage_reg_t ex_mem_stage_reg,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              stall_mem,
    output mem_wb_stage_reg_t mem_wb_stage_reg
);

    mem_state_t        state_r;
    mem_state_t        state_next_s;
    logic [31:0]       addr_r;
    logic [31:0]       wdata_r;
    logic              access_s;
    logic              is_load_s;
    logic [31:0]       align_ld_s;
    mem_wb_stage_reg_t mem_wb_next_s;

    load_align u_load_align (
        .load_op (ex_mem_stage_reg.load_op),
        .off     (ex_mem_stage_reg.mem_addr[1:0]),
        .rdata   (dmem_rdata),
        .ld_data (align_ld_s)
    );

    // Classify the EX/MEM instruction; a read mask wins over a write mask.
    always_comb begin
        is_load_s = ex_mem_stage_reg.valid && (ex_mem_stage_reg.mem_rmask != 4'h0);
        access_s  = rst_n && ex_mem_stage_reg.valid &&
                    ((ex_mem_stage_reg.mem_rmask != 4'h0) || (ex_mem_stage_reg.mem_wmask != 4'h0));
    end

    // Next-state and memory-interface outputs; masks pulse only in the issue cycle.
    always_comb begin
        state_next_s = state_r;
        dmem_addr    = 32'h0000_0000;
        dmem_rmask   = 4'h0;
        dmem_wmask   = 4'h0;
        dmem_wdata   = 32'h0000_0000;
        stall_mem    = 1'b0;
        case (state_r)
            mem_idle: begin
                if (access_s) begin
                    dmem_addr = {ex_mem_stage_reg.mem_addr[31:2], 2'b00};
                    if (is_load_s) begin
                        dmem_rmask = ex_mem_stage_reg.mem_rmask;
                    end else begin
                        dmem_wmask = ex_mem_stage_reg.mem_wmask;
                        dmem_wdata = ex_mem_stage_reg.mem_wdata;
                    end
                    stall_mem    = 1'b1;
                    state_next_s = mem_wait;
                end else begin
                    state_next_s = mem_idle;
                end
            end
            mem_wait: begin
                dmem_addr  = addr_r;
                dmem_wdata = wdata_r;
                if (dmem_resp) begin
                    stall_mem    = 1'b0;
                    state_next_s = mem_idle;
                end else begin
                    stall_mem    = 1'b1;
                    state_next_s = mem_wait;
                end
            end
            default: begin
                state_next_s = mem_idle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= mem_idle;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Hold the issued address and store data steady while waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if ((state_r == mem_idle) && access_s) begin
            addr_r  <= dmem_addr;
            wdata_r <= dmem_wdata;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Assemble the MEM/WB payload from EX/MEM plus the (aligned) load data.
    always_comb begin
        mem_wb_next_s            = '0;
        mem_wb_next_s.valid      = ex_mem_stage_reg.valid;
        mem_wb_next_s.pc         = ex_mem_stage_reg.pc;
        mem_wb_next_s.pc_next    = ex_mem_stage_reg.pc_next;
        mem_wb_next_s.order      = ex_mem_stage_reg.order;
        mem_wb_next_s.inst       = ex_mem_stage_reg.inst;
        mem_wb_next_s.rs1_s      = ex_mem_stage_reg.rs1_s;
        mem_wb_next_s.rs2_s      = ex_mem_stage_reg.rs2_s;
        mem_wb_next_s.rs1_v      = ex_mem_stage_reg.rs1_v;
        mem_wb_next_s.rs2_v      = ex_mem_stage_reg.rs2_v;
        mem_wb_next_s.rd_s       = ex_mem_stage_reg.rd_s;
        mem_wb_next_s.control_wb = ex_mem_stage_reg.control_wb;
        mem_wb_next_s.alu_out    = ex_mem_stage_reg.alu_out;
        mem_wb_next_s.branch     = ex_mem_stage_reg.branch;
        mem_wb_next_s.u_imm      = ex_mem_stage_reg.u_imm;
        mem_wb_next_s.mem_addr   = ex_mem_stage_reg.mem_addr;
        mem_wb_next_s.mem_rmask  = ex_mem_stage_reg.mem_rmask;
        mem_wb_next_s.mem_wmask  = ex_mem_stage_reg.mem_wmask;
        mem_wb_next_s.mem_wdata  = ex_mem_stage_reg.mem_wdata;
        if (is_load_s) begin
            mem_wb_next_s.mem_rdata = dmem_rdata;
            mem_wb_next_s.ld_data   = align_ld_s;
        end else begin
            mem_wb_next_s.mem_rdata = 32'h0000_0000;
            mem_wb_next_s.ld_data   = 32'h0000_0000;
        end
    end

    // MEM/WB register: a bubble while stalled so WB retires each instruction once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_wb_stage_reg <= '0;
        end else if (stall_mem) begin
            mem_wb_stage_reg <= '0;
        end else begin
            mem_wb_stage_reg <= mem_wb_next_s;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
    import rv32i_types::*;

    logic              clk;
    logic              rst_n;
    ex_mem_stage_reg_t ex_mem;
    logic [31:0]       dmem_addr;
    logic [3:0]        dmem_rmask;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;
    logic              stall_mem;
    mem_wb_stage_reg_t mem_wb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // observations recorded by run_access
    int                stall_cnt, rpulse, wpulse, retire_cnt, retire_idx, issue_cyc;
    logic [3:0]        obs_rmask, obs_wmask;
    logic [31:0]       obs_addr, obs_wdata, wait_addr;
    mem_wb_stage_reg_t wb_last;

    mem_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_mem_stage_reg (ex_mem),
        .dmem_addr        (dmem_addr),
        .dmem_rmask       (dmem_rmask),
        .dmem_wmask       (dmem_wmask),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .stall_mem        (stall_mem),
        .mem_wb_stage_reg (mem_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ex_mem_stage_reg_t mk_ex(input logic v, input logic [31:0] addr,
            input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd,
            input load_ops lop, input logic we, input logic [31:0] alu);
        ex_mem_stage_reg_t e;
        e = '0;
        e.valid = v;
        e.pc = 32'h0000_1000 + addr;
        e.pc_next = 32'h0000_1004 + addr;
        e.order = {32'h0, addr};
        e.inst = 32'h0000_0003;
        e.rd_s = 5'd7;
        e.control_wb.regf_we = we;
        e.alu_out = alu;
        e.mem_addr = addr;
        e.mem_rmask = rm;
        e.mem_wmask = wm;
        e.mem_wdata = wd;
        e.load_op = lop;
        return e;
    endfunction

    // Drive one instruction with n_wait wait cycles (resp in the last), recording outputs.
    task automatic run_access(input ex_mem_stage_reg_t ex, input int n_wait, input logic [31:0] rdata);
        stall_cnt = 0; rpulse = 0; wpulse = 0; retire_cnt = 0; retire_idx = -1; issue_cyc = -1;
        obs_rmask = 4'h0; obs_wmask = 4'h0; obs_addr = 32'h0; obs_wdata = 32'h0; wait_addr = 32'h0;
        ex_mem = ex;
        for (int i = 0; i <= n_wait; i++) begin
            dmem_resp  = (n_wait > 0) && (i == n_wait);
            dmem_rdata = (i == n_wait) ? rdata : 32'hA5A5_A5A5;
            @(negedge clk);
            if (stall_mem) stall_cnt++;
            if (dmem_rmask != 4'h0) begin
                rpulse++; obs_rmask = dmem_rmask; obs_addr = dmem_addr; issue_cyc = cyc;
            end
            if (dmem_wmask != 4'h0) begin
                wpulse++; obs_wmask = dmem_wmask; obs_addr = dmem_addr; obs_wdata = dmem_wdata;
                issue_cyc = cyc;
            end
            if (i == 1) wait_addr = dmem_addr;
            @(posedge clk); #1;
            if (mem_wb.valid) begin
                retire_cnt++; retire_idx = i; wb_last = mem_wb;
            end
        end
        ex_mem = '0;
        dmem_resp = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ex_mem = '0; dmem_resp = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dmem_rmask, dmem_wmask, stall_mem, dmem_addr} !== 41'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {dmem_rmask, dmem_wmask, stall_mem, dmem_addr});
        end
        checks++;
        if (mem_wb.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mem_wb.valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_alu;
        ex_mem = mk_ex(1'b1, 32'h0, 4'h0, 4'h0, 32'h0, load_lw, 1'b1, 32'h0000_1234);
        @(negedge clk);
        checks++;
        if ({stall_mem, dmem_rmask, dmem_wmask} !== 9'h0) begin
            errors++; $display("FAIL alu_no_req: got %h expected 0", {stall_mem, dmem_rmask, dmem_wmask});
        end
        @(posedge clk); #1;
        ex_mem = '0;
        checks++;
        if (mem_wb.valid !== 1'b1 || mem_wb.alu_out !== 32'h0000_1234 || mem_wb.ld_data !== 32'h0) begin
            errors++; $display("FAIL alu_retire: got v=%b alu=%h ld=%h expected v=1 alu=00001234 ld=0",
                               mem_wb.valid, mem_wb.alu_out, mem_wb.ld_data);
        end
    endtask

    task automatic test_lw;
        run_access(mk_ex(1'b1, 32'h100, 4'hF, 4'h0, 32'h0, load_lw, 1'b1, 32'h100), 3, 32'hDEAD_BEEF);
        checks++;
        if (rpulse !== 1 || obs_rmask !== 4'hF || obs_addr !== 32'h100 || wpulse !== 0) begin
            errors++; $display("FAIL lw_request: got pulses=%0d mask=%h addr=%h expected 1 F 00000100", rpulse, obs_rmask, obs_addr);
        end
        checks++;
        if (wait_addr !== 32'h100) begin errors++; $display("FAIL lw_addr_hold: got %h expected 00000100", wait_addr); end
        checks++;
        if (stall_cnt !== 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d expected 3", stall_cnt); end
        checks++;
        if (retire_cnt !== 1 || retire_idx !== 3) begin
            errors++; $display("FAIL lw_retire: got count=%0d at=%0d expected 1 at 3", retire_cnt, retire_idx);
        end
        checks++;
        if (wb_last.ld_data !== 32'hDEAD_BEEF || wb_last.mem_rdata !== 32'hDEAD_BEEF || wb_last.control_wb.regf_we !== 1'b1) begin
            errors++; $display("FAIL lw_data: got ld=%h rd=%h we=%b expected DEADBEEF DEADBEEF 1",
                               wb_last.ld_data, wb_last.mem_rdata, wb_last.control_wb.regf_we);
        end
    endtask

    task automatic test_byte_half;
        run_access(mk_ex(1'b1, 32'h103, 4'b1000, 4'h0, 32'h0, load_lb, 1'b1, 32'h103), 1, 32'h80FF_FFFF);
        checks++;
        if (obs_rmask !== 4'b1000 || obs_addr !== 32'h100 || wb_last.ld_data !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_0x103: got mask=%h addr=%h ld=%h expected 8 00000100 FFFFFF80", obs_rmask, obs_addr, wb_last.ld_data);
        end
        run_access(mk_ex(1'b1, 32'h103, 4'b1000, 4'h0, 32'h0, load_lbu, 1'b1, 32'h103), 1, 32'h80FF_FFFF);
        checks++;
        if (wb_last.ld_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_0x103: got %h expected 00000080", wb_last.ld_data); end
        run_access(mk_ex(1'b1, 32'h101, 4'b0010, 4'h0, 32'h0, load_lb, 1'b1, 32'h101), 1, 32'h0000_7F00);
        checks++;
        if (wb_last.ld_data !== 32'h0000_007F) begin errors++; $display("FAIL lb_0x101: got %h expected 0000007F", wb_last.ld_data); end
        run_access(mk_ex(1'b1, 32'h102, 4'b1100, 4'h0, 32'h0, load_lhu, 1'b1, 32'h102), 1, 32'h80FF_FFFF);
        checks++;
        if (wb_last.ld_data !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_0x102: got %h expected 000080FF", wb_last.ld_data); end
        run_access(mk_ex(1'b1, 32'h102, 4'b1100, 4'h0, 32'h0, load_lh, 1'b1, 32'h102), 1, 32'h80FF_FFFF);
        checks++;
        if (wb_last.ld_data !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_0x102: got %h expected FFFF80FF", wb_last.ld_data); end
    endtask

    task automatic test_store;
        run_access(mk_ex(1'b1, 32'h102, 4'h0, 4'b1100, 32'hBEEF_0000, load_lw, 1'b0, 32'h102), 2, 32'h1111_1111);
        checks++;
        if (wpulse !== 1 || obs_wmask !== 4'b1100 || obs_addr !== 32'h100 || obs_wdata !== 32'hBEEF_0000 || rpulse !== 0) begin
            errors++; $display("FAIL sh_request: got pulses=%0d mask=%h addr=%h wdata=%h expected 1 C 00000100 BEEF0000",
                               wpulse, obs_wmask, obs_addr, obs_wdata);
        end
        checks++;
        if (stall_cnt !== 2) begin errors++; $display("FAIL sh_stall_cycles: got %0d expected 2", stall_cnt); end
        checks++;
        if (retire_cnt !== 1 || wb_last.control_wb.regf_we !== 1'b0 || wb_last.mem_rdata !== 32'h0) begin
            errors++; $display("FAIL sh_retire: got count=%0d we=%b rd=%h expected 1 0 0", retire_cnt, wb_last.control_wb.regf_we, wb_last.mem_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int first_issue;
        int first_retire;
        mem_wb_stage_reg_t first_wb;
        run_access(mk_ex(1'b1, 32'h200, 4'hF, 4'h0, 32'h0, load_lw, 1'b1, 32'h200), 1, 32'h1122_3344);
        first_issue = issue_cyc; first_retire = retire_cnt; first_wb = wb_last;
        run_access(mk_ex(1'b1, 32'h204, 4'h0, 4'hF, 32'h5566_7788, load_lw, 1'b0, 32'h204), 1, 32'h9999_9999);
        checks++;
        if (issue_cyc - first_issue !== 2) begin
            errors++; $display("FAIL b2b_spacing: got %0d expected 2", issue_cyc - first_issue);
        end
        checks++;
        if (first_retire !== 1 || retire_cnt !== 1) begin
            errors++; $display("FAIL b2b_retire_once: got %0d,%0d expected 1,1", first_retire, retire_cnt);
        end
        checks++;
        if (first_wb.ld_data !== 32'h1122_3344 || wb_last.mem_wmask !== 4'hF || wb_last.mem_wdata !== 32'h5566_7788) begin
            errors++; $display("FAIL b2b_payload: got ld=%h wm=%h wd=%h expected 11223344 F 55667788",
                               first_wb.ld_data, wb_last.mem_wmask, wb_last.mem_wdata);
        end
    endtask

    task automatic test_invalid_and_both;
        ex_mem = mk_ex(1'b0, 32'h300, 4'hF, 4'hF, 32'h1, load_lw, 1'b1, 32'h0);
        @(negedge clk);
        checks++;
        if ({stall_mem, dmem_rmask, dmem_wmask} !== 9'h0) begin
            errors++; $display("FAIL invalid_no_req: got %h expected 0", {stall_mem, dmem_rmask, dmem_wmask});
        end
        @(posedge clk); #1;
        run_access(mk_ex(1'b1, 32'h400, 4'b0011, 4'b0011, 32'h0000_ABCD, load_lh, 1'b1, 32'h400), 1, 32'h1234_8001);
        checks++;
        if (rpulse !== 1 || wpulse !== 0 || wb_last.ld_data !== 32'hFFFF_8001) begin
            errors++; $display("FAIL read_wins: got r=%0d w=%0d ld=%h expected 1 0 FFFF8001", rpulse, wpulse, wb_last.ld_data);
        end
    endtask

    task automatic test_reset_in_wait;
        ex_mem = mk_ex(1'b1, 32'h300, 4'hF, 4'h0, 32'h0, load_lw, 1'b1, 32'h300);
        dmem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_rmask !== 4'hF) begin errors++; $display("FAIL rst_wait_issue: got %h expected F", dmem_rmask); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ex_mem = '0;
        @(negedge clk);
        checks++;
        if ({stall_mem, dmem_rmask, dmem_wmask} !== 9'h0 || mem_wb.valid !== 1'b0) begin
            errors++; $display("FAIL rst_wait_idle: got stall/masks=%h valid=%b expected 0 0",
                               {stall_mem, dmem_rmask, dmem_wmask}, mem_wb.valid);
        end
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b0) begin errors++; $display("FAIL idle_resp_stall: got %b expected 0", stall_mem); end
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        checks++;
        if (mem_wb.valid !== 1'b0) begin errors++; $display("FAIL idle_resp_retire: got %b expected 0", mem_wb.valid); end
        ex_mem = mk_ex(1'b1, 32'h0, 4'h0, 4'h0, 32'h0, load_lw, 1'b1, 32'h0000_0077);
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b0) begin errors++; $display("FAIL idle_after_resp: got %b expected 0", stall_mem); end
        @(posedge clk); #1;
        ex_mem = '0;
        checks++;
        if (mem_wb.valid !== 1'b1 || mem_wb.alu_out !== 32'h0000_0077) begin
            errors++; $display("FAIL alu_after_reset: got v=%b alu=%h expected 1 00000077", mem_wb.valid, mem_wb.alu_out);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw();
        test_byte_half();
        test_store();
        test_back_to_back();
        test_invalid_and_both();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
